mem_port_arbiter: RTL

- Shares the single-port data RAM between two requesters: instruction fetch (read-only) and load/store (read/write).
- The RAM has these properties:
  - Write select is 3-bit: bit0 = word, bit1 = halfword, bit2 = byte.
  - Read data is registered, one cycle after the address.
  - The RAM itself performs byte-lane placement.
- This block arbitrates round-robin, sequences each access through a fixed 4-state FSM, rejects illegal stores and out-of-range addresses, and returns registered responses.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port data RAM between instruction fetch and load/store.
// Latency : legal access 4 cycles (IDLE, ACCESS, CAPTURE, RESP), rejected access 2 cycles (IDLE, RESP).
// Backpr. : requesters hold req until their one-cycle ready strobe; requests are sampled only in IDLE.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_req/i_addr                 fetch request (read-only)
//   i_ready/i_rdata/i_err        fetch response strobe, held read data, error flag
//   d_req/d_we/d_addr/d_wdata    load/store request (d_we: 0 load, bit0 word, bit1 half, bit2 byte)
//   d_ready/d_rdata/d_err        load/store response strobe, held read data, error flag
//   mem_write_enable/mem_addr/mem_data_in/mem_data_out   RAM side (read data registered by RAM)
module mem_port_arbiter #(
  parameter int unsigned ADDR_LIMIT = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [2:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [2:0]  mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_gnt_d_q, last_gnt_d_d;   // 1: data port was granted last
  logic        gnt_d_q, gnt_d_d;             // 1: current transaction belongs to data port
  logic [31:0] addr_q, addr_d;
  logic [2:0]  we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        i_ready_q, i_ready_d;
  logic        i_err_q, i_err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_ready_q, d_ready_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // Arbitration and request decode, evaluated on the values that IDLE latches.
  logic        grant_any;
  logic        sel_d;
  logic [31:0] addr_sel;
  logic [2:0]  we_sel;
  logic        multi_sel;
  logic        req_err;

  always_comb begin
    grant_any = i_req | d_req;
    // On contention the port that did not win last time is served.
    sel_d     = d_req & (~i_req | ~last_gnt_d_q);
    addr_sel  = sel_d ? d_addr : i_addr;
    we_sel    = sel_d ? d_we : 3'b000;
    multi_sel = (we_sel[0] & we_sel[1]) | (we_sel[0] & we_sel[2]) | (we_sel[1] & we_sel[2]);
    req_err   = (addr_sel >= LIMIT)
              | multi_sel
              | ((we_sel == 3'b001) & (addr_sel[1:0] != 2'b00))
              | ((we_sel == 3'b010) & addr_sel[0]);
  end

  always_comb begin
    state_d      = state_q;
    last_gnt_d_d = last_gnt_d_q;
    gnt_d_d      = gnt_d_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    i_ready_d    = 1'b0;
    i_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_ready_d    = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          gnt_d_d      = sel_d;
          last_gnt_d_d = sel_d;
          addr_d       = addr_sel;
          we_d         = we_sel;
          wdata_d      = sel_d ? d_wdata : 32'd0;
          if (req_err) begin
            // Rejected: skip the RAM entirely, rdata registers keep their value.
            state_d = RESP;
            if (sel_d) begin
              d_ready_d = 1'b1;
              d_err_d   = 1'b1;
            end else begin
              i_ready_d = 1'b1;
              i_err_d   = 1'b1;
            end
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // RAM read data for the ACCESS address is valid now (pre-write word on stores).
        state_d = RESP;
        if (gnt_d_q) begin
          d_ready_d = 1'b1;
          d_rdata_d = mem_data_out;
        end else begin
          i_ready_d = 1'b1;
          i_rdata_d = mem_data_out;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_gnt_d_q <= 1'b1;
      gnt_d_q      <= 1'b0;
      addr_q       <= 32'd0;
      we_q         <= 3'b000;
      wdata_q      <= 32'd0;
      i_ready_q    <= 1'b0;
      i_err_q      <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_ready_q    <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_gnt_d_q <= last_gnt_d_d;
      gnt_d_q      <= gnt_d_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      i_ready_q    <= i_ready_d;
      i_err_q      <= i_err_d;
      i_rdata_q    <= i_rdata_d;
      d_ready_q    <= d_ready_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Write strobe exists only while in ACCESS; address and data simply hold the latch.
  assign mem_write_enable = (state_q == ACCESS) ? we_q : 3'b000;
  assign mem_addr         = addr_q;
  assign mem_data_in      = wdata_q;

  assign i_ready = i_ready_q;
  assign i_err   = i_err_q;
  assign i_rdata = i_rdata_q;
  assign d_ready = d_ready_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;

endmodule
